// File: rtl/pl_framing_pkg.sv
// Shared framing definitions for the PL TX path: Gen1/2 K-characters,
// the arbiter state encoding and the fixed DLLP payload length.
package pl_framing_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  localparam int DLLP_LEN = 6;

  typedef enum logic [1:0] {
    IDLE,
    TLP,
    FLUSH
  } tx_state_e;

endpackage

// File: rtl/pl_tx_realign.sv
// TLP beat builder: one-byte carry realignment behind STP plus END/PAD
// insertion on the last beat, the flush beat and the EDB abort beat.
module pl_tx_realign
  import pl_framing_pkg::*;
#(
  parameter int BYTES = 64
) (
  input  logic [8*BYTES-1:0]     in_data,
  input  logic [$clog2(BYTES):0] nbytes,
  input  logic [7:0]             carry_in,
  input  logic                   first,
  input  logic                   last,
  input  logic                   flush,
  input  logic                   flush_carry,
  input  logic                   abort,
  output logic [8*BYTES-1:0]     out_data,
  output logic [BYTES-1:0]       out_dk,
  output logic [7:0]             carry_out
);

  always_comb begin
    out_data  = '0;
    out_dk    = '0;
    carry_out = carry_in;
    if (abort) begin
      for (int i = 0; i < BYTES; i++) out_data[8*i +: 8] = K_PAD;
      out_data[7:0] = K_EDB;
      out_dk        = '1;
    end else if (flush) begin
      for (int i = 0; i < BYTES; i++) out_data[8*i +: 8] = K_PAD;
      out_dk = '1;
      if (flush_carry) begin
        out_data[7:0]  = carry_in;
        out_dk[0]      = 1'b0;
        out_data[15:8] = K_END;
      end else begin
        out_data[7:0] = K_END;
      end
    end else begin
      // Every beat is shifted up one byte; the top input byte waits in the carry.
      out_data  = {in_data[8*BYTES-9:0], first ? K_STP : carry_in};
      out_dk[0] = first;
      carry_out = in_data[8*BYTES-1 -: 8];
      if (last) begin
        for (int i = 1; i < BYTES; i++) begin
          if (i == int'(nbytes) + 1) begin
            out_data[8*i +: 8] = K_END;
            out_dk[i]          = 1'b1;
          end else if (i > int'(nbytes) + 1) begin
            out_data[8*i +: 8] = K_PAD;
            out_dk[i]          = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pl_tx_packet_arbiter.sv
// TX framing arbiter sharing one lane bus between TLP and DLLP sources.
// Optional PL_TX_STATS_EN adds saturating tlp_count/dllp_count outputs.
module pl_tx_packet_arbiter
  import pl_framing_pkg::*;
#(
  parameter int BYTES        = 64,
  parameter int MAX_DLLP_RUN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   linkup,
  input  logic                   tlp_valid,
  output logic                   tlp_ready,
  input  logic [8*BYTES-1:0]     tlp_data,
  input  logic                   tlp_last,
  input  logic [$clog2(BYTES):0] tlp_nbytes,
  input  logic                   dllp_valid,
  output logic                   dllp_ready,
  input  logic [47:0]            dllp_data,
  output logic [8*BYTES-1:0]     pl_data,
  output logic [BYTES-1:0]       pl_dk,
  output logic                   pl_valid
`ifdef PL_TX_STATS_EN
  ,
  output logic [15:0]            tlp_count,
  output logic [15:0]            dllp_count
`endif
);

  localparam int RW = $clog2(MAX_DLLP_RUN + 1);

  tx_state_e          state;
  tx_state_e          tlp_next;
  logic [RW-1:0]      run_cnt;
  logic [7:0]         carry;
  logic               flush_carry;
  logic               tlp_win;
  logic               ends_here;
  logic [8*BYTES-1:0] rl_data;
  logic [BYTES-1:0]   rl_dk;
  logic [7:0]         rl_carry;
  logic [8*BYTES-1:0] dllp_beat;
  logic [BYTES-1:0]   dllp_dk;

  assign tlp_win    = tlp_valid && (!dllp_valid || run_cnt == RW'(MAX_DLLP_RUN));
  assign tlp_ready  = !rst && linkup &&
                      ((state == TLP && tlp_valid) || (state == IDLE && tlp_win));
  assign dllp_ready = !rst && linkup && dllp_valid && state == IDLE && !tlp_win;
  assign ends_here  = tlp_last && (int'(tlp_nbytes) <= BYTES - 2);
  assign tlp_next   = !tlp_last ? TLP : (ends_here ? IDLE : FLUSH);

  always_comb begin
    for (int i = 0; i < BYTES; i++) dllp_beat[8*i +: 8] = K_PAD;
    dllp_dk                              = '1;
    dllp_beat[7:0]                       = K_SDP;
    dllp_beat[8 +: 8*DLLP_LEN]           = dllp_data;
    dllp_beat[8*(DLLP_LEN+1) +: 8]       = K_END;
    dllp_dk[DLLP_LEN:1]                  = '0;
  end

  pl_tx_realign #(.BYTES(BYTES)) u_realign (
    .in_data    (tlp_data),
    .nbytes     (tlp_nbytes),
    .carry_in   (carry),
    .first      (state == IDLE),
    .last       (tlp_last),
    .flush      (state == FLUSH),
    .flush_carry(flush_carry),
    .abort      (state != IDLE && !linkup),
    .out_data   (rl_data),
    .out_dk     (rl_dk),
    .carry_out  (rl_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      run_cnt     <= '0;
      carry       <= '0;
      flush_carry <= 1'b0;
      pl_data     <= '0;
      pl_dk       <= '0;
      pl_valid    <= 1'b0;
    end else begin
      pl_data  <= '0;
      pl_dk    <= '0;
      pl_valid <= 1'b0;
      if (!tlp_valid) run_cnt <= '0;
      case (state)
        IDLE: begin
          if (tlp_ready) begin
            pl_data     <= rl_data;
            pl_dk       <= rl_dk;
            pl_valid    <= 1'b1;
            carry       <= rl_carry;
            flush_carry <= (int'(tlp_nbytes) == BYTES);
            run_cnt     <= '0;
            state       <= tlp_next;
          end else if (dllp_ready) begin
            pl_data  <= dllp_beat;
            pl_dk    <= dllp_dk;
            pl_valid <= 1'b1;
            if (tlp_valid) run_cnt <= run_cnt + RW'(1);
          end
        end
        TLP: begin
          if (!linkup) begin
            pl_data  <= rl_data;
            pl_dk    <= rl_dk;
            pl_valid <= 1'b1;
            state    <= IDLE;
          end else if (tlp_ready) begin
            pl_data     <= rl_data;
            pl_dk       <= rl_dk;
            pl_valid    <= 1'b1;
            carry       <= rl_carry;
            flush_carry <= (int'(tlp_nbytes) == BYTES);
            state       <= tlp_next;
          end
        end
        FLUSH: begin
          // The realigner picks EDB over the flush beat when the link dropped.
          pl_data  <= rl_data;
          pl_dk    <= rl_dk;
          pl_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PL_TX_STATS_EN
  logic tlp_end_evt;
  assign tlp_end_evt = (state != IDLE && !linkup) || (state == FLUSH) ||
                       (tlp_ready && ends_here);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlp_count  <= '0;
      dllp_count <= '0;
    end else begin
      if (tlp_end_evt && tlp_count != 16'hFFFF) tlp_count <= tlp_count + 16'd1;
      if (dllp_ready && dllp_count != 16'hFFFF) dllp_count <= dllp_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pl_tx_packet_arbiter.sv
// Scoreboard bench for pl_tx_packet_arbiter (BYTES=8, MAX_DLLP_RUN=2):
// directed framing cases followed by randomized traffic against a byte-stream model.
module tb_pl_tx_packet_arbiter;

  localparam int BYTES   = 8;
  localparam int MAX_RUN = 2;
  localparam int NBW     = $clog2(BYTES) + 1;

  localparam logic [7:0] STP  = 8'hFB;
  localparam logic [7:0] SDP  = 8'h5C;
  localparam logic [7:0] ENDK = 8'hFD;
  localparam logic [7:0] PAD  = 8'hF7;

  logic             clk = 1'b0;
  logic             rst;
  logic             linkup;
  logic             tlp_valid;
  logic             tlp_ready;
  logic [63:0]      tlp_data;
  logic             tlp_last;
  logic [NBW-1:0]   tlp_nbytes;
  logic             dllp_valid;
  logic             dllp_ready;
  logic [47:0]      dllp_data;
  logic [63:0]      pl_data;
  logic [7:0]       pl_dk;
  logic             pl_valid;
`ifdef PL_TX_STATS_EN
  logic [15:0]      tlp_count;
  logic [15:0]      dllp_count;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_tlp_cnt  = 0;
  int exp_dllp_cnt = 0;

  logic [63:0] exp_data_q[$];
  logic [7:0]  exp_dk_q[$];

  pl_tx_packet_arbiter #(.BYTES(BYTES), .MAX_DLLP_RUN(MAX_RUN)) dut (
    .clk       (clk),
    .rst       (rst),
    .linkup    (linkup),
    .tlp_valid (tlp_valid),
    .tlp_ready (tlp_ready),
    .tlp_data  (tlp_data),
    .tlp_last  (tlp_last),
    .tlp_nbytes(tlp_nbytes),
    .dllp_valid(dllp_valid),
    .dllp_ready(dllp_ready),
    .dllp_data (dllp_data),
    .pl_data   (pl_data),
    .pl_dk     (pl_dk),
    .pl_valid  (pl_valid)
`ifdef PL_TX_STATS_EN
    ,
    .tlp_count (tlp_count),
    .dllp_count(dllp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkReady(input int exp_t, input int exp_d);
    checkOutput("tlp_ready", 64'(tlp_ready), 64'(exp_t != 0));
    checkOutput("dllp_ready", 64'(dllp_ready), 64'(exp_d != 0));
  endtask

  // One bus cycle: drive after the rising edge, return at the falling edge.
  task automatic applyStimulus(input int lu, input int tv, input logic [63:0] td, input int tl,
                               input int tn, input int dv, input logic [47:0] dd);
    @(posedge clk);
    #1;
    linkup     = (lu != 0);
    tlp_valid  = (tv != 0);
    tlp_data   = td;
    tlp_last   = (tl != 0);
    tlp_nbytes = NBW'(tn);
    dllp_valid = (dv != 0);
    dllp_data  = dd;
    @(negedge clk);
  endtask

  task automatic pushExpected(input logic [63:0] d, input logic [7:0] k);
    exp_data_q.push_back(d);
    exp_dk_q.push_back(k);
  endtask

  // Reference: a TLP is the byte stream STP,payload,END padded with PAD and cut into beats.
  task automatic pushTlp(input logic [7:0] pkt[$]);
    logic [7:0] sb[$];
    logic       sk[$];
    logic [63:0] d;
    logic [7:0]  k;
    sb.push_back(STP);
    sk.push_back(1'b1);
    foreach (pkt[i]) begin
      sb.push_back(pkt[i]);
      sk.push_back(1'b0);
    end
    sb.push_back(ENDK);
    sk.push_back(1'b1);
    while (sb.size() % BYTES != 0) begin
      sb.push_back(PAD);
      sk.push_back(1'b1);
    end
    for (int b = 0; b < sb.size() / BYTES; b++) begin
      for (int i = 0; i < BYTES; i++) begin
        d[8*i +: 8] = sb[b*BYTES + i];
        k[i]        = sk[b*BYTES + i];
      end
      pushExpected(d, k);
    end
    exp_tlp_cnt++;
  endtask

  task automatic pushDllp(input logic [47:0] dd);
    logic [63:0] d;
    d[7:0] = SDP;
    for (int i = 0; i < 6; i++) d[8*(i+1) +: 8] = dd[8*i +: 8];
    d[63:56] = ENDK;
    pushExpected(d, 8'h81);
    exp_dllp_cnt++;
  endtask

  // Monitor: every valid beat is matched against the scoreboard, idle beats must be zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (pl_valid) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: got %h/%h want no beat at %0t", pl_data, pl_dk, $time);
        end else begin
          checkOutput("pl_data", pl_data, exp_data_q.pop_front());
          checkOutput("pl_dk", 64'(pl_dk), 64'(exp_dk_q.pop_front()));
        end
      end else begin
        checkOutput("idle_data", pl_data, 64'd0);
        checkOutput("idle_dk", 64'(pl_dk), 64'd0);
      end
    end
  end

  initial begin
    logic [7:0]  pkt_a[$];
    logic [7:0]  pkt[$];
    logic [63:0] td;
    logic [47:0] cur_dd;
    int          beat_idx;
    int          rem;
    int          run;
    int          tl;
    int          tn;
    int          exp_t;
    int          exp_d;
    int          cyc;
    bit          pkt_loaded;
    bit          pkt_open;
    bit          flush_pend;
    bit          was_flush;
    bit          cur_tv;
    bit          cur_dv;
    bit          gen;

    rst = 1'b1;
    linkup = 1'b0;
    tlp_valid = 1'b0;
    tlp_data = '0;
    tlp_last = 1'b0;
    tlp_nbytes = '0;
    dllp_valid = 1'b0;
    dllp_data = '0;
    @(negedge clk);
    checkOutput("reset_pl_data", pl_data, 64'd0);
    checkOutput("reset_pl_dk", 64'(pl_dk), 64'd0);
    checkOutput("reset_pl_valid", 64'(pl_valid), 64'd0);
    checkReady(0, 0);
    rst = 1'b0;

    // DLLP framing
    applyStimulus(1, 0, 64'd0, 0, 0, 1, 48'h112233445566);
    checkReady(0, 1);
    pushExpected(64'hFD112233445566_5C, 8'h81);
    exp_dllp_cnt++;
    applyStimulus(1, 0, 64'd0, 0, 0, 0, 48'd0);

    // Short single-beat TLP, then a DLLP is granted straight away
    applyStimulus(1, 1, 64'h55555555_A3A2A1A0, 1, 4, 0, 48'd0);
    checkReady(1, 0);
    pushExpected(64'hF7F7FDA3A2A1A0FB, 8'hE1);
    applyStimulus(1, 0, 64'd0, 0, 0, 1, 48'hCAFE00BEEF01);
    checkReady(0, 1);
    pushDllp(48'hCAFE00BEEF01);

    // Full-width single-beat TLP needs a flush beat; a waiting TLP is held off
    applyStimulus(1, 1, 64'hA7A6A5A4A3A2A1A0, 1, 8, 0, 48'd0);
    checkReady(1, 0);
    pushExpected(64'hA6A5A4A3A2A1A0FB, 8'h01);
    pushExpected(64'hF7F7F7F7F7F7FDA7, 8'hFE);
    applyStimulus(1, 1, 64'h12345678_9ABCB1B0, 1, 2, 0, 48'd0);
    checkReady(0, 0);
    applyStimulus(1, 1, 64'h12345678_9ABCB1B0, 1, 2, 0, 48'd0);
    checkReady(1, 0);
    pushExpected(64'hF7F7F7F7FDB1B0FB, 8'hF9);
    applyStimulus(1, 0, 64'd0, 0, 0, 0, 48'd0);

    // Fairness: both sources busy gives D,D,T,D,D,T
    pkt_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 64'h0000_0000_A3A2A1A0, 1, 4, 1, 48'h100000000000 + 48'(i));
      if (i % 3 == 2) begin
        checkReady(1, 0);
        pushTlp(pkt_a);
      end else begin
        checkReady(0, 1);
        pushDllp(48'h100000000000 + 48'(i));
      end
    end
    applyStimulus(1, 0, 64'd0, 0, 0, 0, 48'd0);

    // Link drop mid-packet: EDB beat, nothing more accepted, then idle
    applyStimulus(1, 1, 64'hC7C6C5C4C3C2C1C0, 0, 8, 0, 48'd0);
    checkReady(1, 0);
    pushExpected(64'hC6C5C4C3C2C1C0FB, 8'h01);
    applyStimulus(0, 1, 64'hD7D6D5D4D3D2D1D0, 0, 8, 0, 48'd0);
    checkReady(0, 0);
    pushExpected(64'hF7F7F7F7F7F7F7FE, 8'hFF);
    applyStimulus(0, 1, 64'hD7D6D5D4D3D2D1D0, 0, 8, 0, 48'd0);
    checkReady(0, 0);
    applyStimulus(1, 0, 64'd0, 0, 0, 0, 48'd0);
    checkOutput("post_abort_idle", 64'(pl_valid), 64'd0);

    // Asynchronous reset in the middle of a packet
    applyStimulus(1, 1, 64'hE7E6E5E4E3E2E1E0, 0, 8, 0, 48'd0);
    checkReady(1, 0);
    pushExpected(64'hE6E5E4E3E2E1E0FB, 8'h01);
    applyStimulus(1, 1, 64'hF7F6F5F4F3F2F1F0, 0, 8, 0, 48'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pl_valid", 64'(pl_valid), 64'd0);
    checkOutput("async_rst_pl_dk", 64'(pl_dk), 64'd0);
    checkOutput("async_rst_pl_data", pl_data, 64'd0);
    checkOutput("async_rst_tlp_ready", 64'(tlp_ready), 64'd0);
    tlp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_tlp_cnt  = 0;
    exp_dllp_cnt = 0;
    applyStimulus(1, 0, 64'd0, 0, 0, 1, 48'hA1B2C3D4E5F6);
    checkReady(0, 1);
    pushDllp(48'hA1B2C3D4E5F6);
    applyStimulus(1, 0, 64'd0, 0, 0, 0, 48'd0);

    // Randomized traffic with a spec-level grant model
    run = 0;
    pkt_loaded = 0;
    pkt_open = 0;
    flush_pend = 0;
    cur_tv = 0;
    cur_dv = 0;
    cur_dd = '0;
    beat_idx = 0;
    cyc = 0;
    while (1) begin
      gen = (cyc < 600);
      if (!gen && !pkt_loaded && !cur_dv && !flush_pend) break;
      if (cyc >= 1500) begin
        checks++;
        failures++;
        $display("[TB] FAIL drain_timeout: got busy after %0d cycles want idle", cyc);
        break;
      end
      if (!cur_tv) begin
        if (!pkt_loaded && gen && $urandom_range(0, 3) == 0) begin
          pkt.delete();
          for (int i = 0; i < int'($urandom_range(1, 24)); i++) pkt.push_back(8'($urandom_range(0, 255)));
          pkt_loaded = 1;
          beat_idx = 0;
        end
        if (pkt_loaded) cur_tv = ($urandom_range(0, 3) != 0);
      end
      if (!cur_dv && gen && $urandom_range(0, 2) == 0) begin
        cur_dv = 1;
        cur_dd = {16'($urandom), 32'($urandom)};
      end
      td = {32'($urandom), 32'($urandom)};
      rem = pkt_loaded ? pkt.size() - beat_idx * BYTES : 0;
      tl = (pkt_loaded && rem <= BYTES) ? 1 : 0;
      tn = (tl != 0) ? rem : BYTES;
      for (int i = 0; i < BYTES; i++)
        if (pkt_loaded && beat_idx * BYTES + i < pkt.size()) td[8*i +: 8] = pkt[beat_idx * BYTES + i];

      applyStimulus(1, int'(cur_tv), td, tl, tn, int'(cur_dv), cur_dd);

      was_flush = flush_pend;
      flush_pend = 0;
      exp_t = 0;
      exp_d = 0;
      if (was_flush) begin
        exp_t = 0;
      end else if (pkt_open) begin
        exp_t = int'(cur_tv);
      end else if (cur_tv && (!cur_dv || run == MAX_RUN)) begin
        exp_t = 1;
      end else if (cur_dv) begin
        exp_d = 1;
      end
      checkReady(exp_t, exp_d);

      if (!cur_tv) run = 0;
      if (exp_d != 0) begin
        if (cur_tv) run++;
        pushDllp(cur_dd);
        cur_dv = 0;
      end
      if (exp_t != 0) begin
        if (!pkt_open) begin
          pushTlp(pkt);
          run = 0;
          pkt_open = 1;
        end
        beat_idx++;
        cur_tv = 0;
        if (tl != 0) begin
          pkt_open = 0;
          pkt_loaded = 0;
          flush_pend = (pkt.size() + 2 > beat_idx * BYTES);
        end
      end
      cyc++;
    end

    repeat (3) applyStimulus(1, 0, 64'd0, 0, 0, 0, 48'd0);
    checkOutput("scoreboard_empty", 64'(exp_data_q.size()), 64'd0);
`ifdef PL_TX_STATS_EN
    checkOutput("tlp_count", 64'(tlp_count), 64'(exp_tlp_cnt));
    checkOutput("dllp_count", 64'(dllp_count), 64'(exp_dllp_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
